// File: rtl/clock_pkg.sv
// clock_pkg: field limits and divider width helper shared by the time-keeping blocks
package clock_pkg;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int NOON     = 12;

    function automatic int div_w(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction
endpackage

// File: rtl/time_of_day_counter_if.sv
// time_of_day_counter_if: control, set and display/pulse signals of the time-of-day counter
interface time_of_day_counter_if #(parameter int FIELD_W = 8);
    logic               run;
    logic               set;
    logic               mode_12h;
    logic [FIELD_W-1:0] newHours;
    logic [FIELD_W-1:0] newMinutes;
    logic [FIELD_W-1:0] newSeconds;
    logic [FIELD_W-1:0] hours;
    logic [FIELD_W-1:0] minutes;
    logic [FIELD_W-1:0] seconds;
    logic               pm;
    logic               sec_tick;
    logic               min_tick;
    logic               hour_tick;
    logic               day_wrap;
    logic               set_err;

    modport master (
        output run, set, mode_12h, newHours, newMinutes, newSeconds,
        input  hours, minutes, seconds, pm, sec_tick, min_tick, hour_tick, day_wrap, set_err
    );
    modport slave (
        input  run, set, mode_12h, newHours, newMinutes, newSeconds,
        output hours, minutes, seconds, pm, sec_tick, min_tick, hour_tick, day_wrap, set_err
    );
endinterface

// File: rtl/tick_divider.sv
// tick_divider: counts 0..DIV-1 while enabled and flags the last count as a tick
module tick_divider import clock_pkg::*; #(
    parameter int CLK_FREQ_HZ   = 100000000,
    parameter int TICKS_PER_SEC = 1
) (
    input  logic CLK100MHZ,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int DIV = CLK_FREQ_HZ / TICKS_PER_SEC;
    localparam int W   = div_w(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && cnt == LAST;

    // clr wins over en so a load restarts a full period even while paused
    always_ff @(posedge CLK100MHZ) begin
        if (reset || clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: HH:MM:SS counter with run/pause, validated set, 12/24 h display
// and registered carry pulses aligned with the updated fields.
module time_of_day_counter import clock_pkg::*; #(
    parameter int CLK_FREQ_HZ   = 100000000,
    parameter int TICKS_PER_SEC = 1,
    parameter int FIELD_W       = 8
) (
    input logic                  CLK100MHZ,
    input logic                  reset,
    time_of_day_counter_if.slave bus
);
    localparam logic [FIELD_W-1:0] S_MAX  = FIELD_W'(SEC_MAX);
    localparam logic [FIELD_W-1:0] M_MAX  = FIELD_W'(MIN_MAX);
    localparam logic [FIELD_W-1:0] H_MAX  = FIELD_W'(HOUR_MAX);
    localparam logic [FIELD_W-1:0] H_NOON = FIELD_W'(NOON);

    logic [FIELD_W-1:0] hr, mn, sc;
    logic tick, set_ok, load, s_wrap, m_wrap, h_wrap;
    logic sec_tick, min_tick, hour_tick, day_wrap, set_err;

    assign set_ok = bus.newHours <= H_MAX && bus.newMinutes <= M_MAX && bus.newSeconds <= S_MAX;
    assign load   = bus.set && set_ok;
    assign s_wrap = sc == S_MAX;
    assign m_wrap = s_wrap && mn == M_MAX;
    assign h_wrap = m_wrap && hr == H_MAX;

    tick_divider #(
        .CLK_FREQ_HZ  (CLK_FREQ_HZ),
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_div (
        .CLK100MHZ(CLK100MHZ),
        .reset    (reset),
        .en       (bus.run),
        .clr      (load),
        .tick     (tick)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            {hr, mn, sc} <= '0;
            {sec_tick, min_tick, hour_tick, day_wrap, set_err} <= '0;
        end else begin
            {sec_tick, min_tick, hour_tick, day_wrap} <= '0;
            set_err <= bus.set && !set_ok;
            if (load) begin
                hr <= bus.newHours;
                mn <= bus.newMinutes;
                sc <= bus.newSeconds;
            end else if (tick) begin
                sc <= s_wrap ? '0 : sc + 1'b1;
                if (s_wrap)
                    mn <= (mn == M_MAX) ? '0 : mn + 1'b1;
                if (m_wrap)
                    hr <= (hr == H_MAX) ? '0 : hr + 1'b1;
                {sec_tick, min_tick, hour_tick, day_wrap} <= {1'b1, s_wrap, m_wrap, h_wrap};
            end
        end
    end

    assign bus.hours     = !bus.mode_12h ? hr : (hr == '0) ? H_NOON : (hr > H_NOON) ? hr - H_NOON : hr;
    assign bus.minutes   = mn;
    assign bus.seconds   = sc;
    assign bus.pm        = hr >= H_NOON;
    assign bus.sec_tick  = sec_tick;
    assign bus.min_tick  = min_tick;
    assign bus.hour_tick = hour_tick;
    assign bus.day_wrap  = day_wrap;
    assign bus.set_err   = set_err;
endmodule

// File: tb/tb_time_of_day_counter.sv
// tb_time_of_day_counter: directed checks of counting, carries, set validation,
// 12 h mapping, pause and reset with a 4-cycle tick period.
module tb_time_of_day_counter;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;

    time_of_day_counter_if #(.FIELD_W(8)) bus ();

    time_of_day_counter #(
        .CLK_FREQ_HZ  (4),
        .TICKS_PER_SEC(1),
        .FIELD_W      (8)
    ) dut (
        .CLK100MHZ(clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        check(tag, {8'h0, bus.hours, bus.minutes, bus.seconds}, {8'h0, h, m, s});
    endtask

    // pulses packed as {sec_tick, min_tick, hour_tick, day_wrap, set_err}
    task automatic check_pulses(input string tag, input logic [4:0] exp);
        check(tag, {27'h0, bus.sec_tick, bus.min_tick, bus.hour_tick, bus.day_wrap, bus.set_err}, {27'h0, exp});
    endtask

    task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus.set = 1'b1;
        bus.newHours = h;
        bus.newMinutes = m;
        bus.newSeconds = s;
        cyc();
        bus.set = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.run = 1'b1;
        bus.set = 1'b0;
        bus.mode_12h = 1'b0;
        bus.newHours = '0;
        bus.newMinutes = '0;
        bus.newSeconds = '0;
        cyc();
        cyc();
        check_time("reset_time", 0, 0, 0);
        check_pulses("reset_pulses", 5'b00000);
        check("reset_pm", {31'h0, bus.pm}, 0);
        bus.mode_12h = 1'b1;
        #1;
        check("reset_12h_hours", {24'h0, bus.hours}, 12);
        bus.mode_12h = 1'b0;
        reset = 1'b0;

        cyc();
        cyc();
        cyc();
        check_time("pre_first_tick", 0, 0, 0);
        check_pulses("pre_first_tick_pulses", 5'b00000);
        cyc();
        check_time("first_tick", 0, 0, 1);
        check_pulses("first_tick_pulses", 5'b10000);
        cyc();
        check_pulses("first_tick_one_cycle", 5'b00000);

        do_set(0, 0, 59);
        check_time("set_00_00_59", 0, 0, 59);
        check_pulses("set_no_pulses", 5'b00000);
        cyc();
        cyc();
        cyc();
        check_time("after_set_wait", 0, 0, 59);
        cyc();
        check_time("min_carry", 0, 1, 0);
        check_pulses("min_carry_pulses", 5'b11000);

        do_set(23, 59, 59);
        repeat (4) cyc();
        check_time("day_wrap_time", 0, 0, 0);
        check_pulses("day_wrap_pulses", 5'b11110);
        cyc();
        check_pulses("day_wrap_one_cycle", 5'b00000);
        check_time("day_wrap_hold", 0, 0, 0);

        do_set(10, 20, 30);
        do_set(24, 0, 0);
        check_time("bad_hour_time", 10, 20, 30);
        check_pulses("bad_hour_err", 5'b00001);
        do_set(12, 60, 0);
        check_time("bad_min_time", 10, 20, 30);
        check_pulses("bad_min_err", 5'b00001);
        cyc();
        check_pulses("err_one_cycle", 5'b00000);
        cyc();
        check_time("tick_after_bad_sets", 10, 20, 31);
        cyc();
        cyc();
        cyc();
        do_set(0, 0, 60);
        check_time("bad_set_with_tick", 10, 20, 32);
        check_pulses("bad_set_with_tick_pulses", 5'b10001);

        bus.mode_12h = 1'b1;
        do_set(0, 15, 0);
        check_time("12h_midnight", 12, 15, 0);
        check("12h_midnight_pm", {31'h0, bus.pm}, 0);
        do_set(13, 0, 0);
        check_time("12h_13", 1, 0, 0);
        check("12h_13_pm", {31'h0, bus.pm}, 1);
        do_set(12, 0, 0);
        check_time("12h_noon", 12, 0, 0);
        check("12h_noon_pm", {31'h0, bus.pm}, 1);
        do_set(23, 0, 0);
        check_time("12h_23", 11, 0, 0);
        bus.mode_12h = 1'b0;
        #1;
        check_time("24h_23", 23, 0, 0);

        do_set(1, 2, 3);
        cyc();
        cyc();
        bus.run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check_time("paused_time", 1, 2, 3);
            check_pulses("paused_pulses", 5'b00000);
        end
        bus.run = 1'b1;
        cyc();
        check_time("resume_partial", 1, 2, 3);
        cyc();
        check_time("resume_tick", 1, 2, 4);
        check_pulses("resume_tick_pulses", 5'b10000);
        cyc();
        reset = 1'b1;
        cyc();
        check_time("mid_reset_time", 0, 0, 0);
        check_pulses("mid_reset_pulses", 5'b00000);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
